// File: rtl/mac_pkg.sv
// Shared MAC subsystem definitions: image float field widths, partial-product
// term format, and the accumulator FSM state encoding.
package mac_pkg;

    // Image float format: {S, E[IMG_EXP_W-1:0], M[IMG_MANT_W-1:0]}
    localparam int unsigned IMG_EXP_W  = 5;
    localparam int unsigned IMG_MANT_W = 2;
    localparam int unsigned IMG_W      = 1 + IMG_EXP_W + IMG_MANT_W;

    // Partial-product term: {sign, leading one, mant[1:0]} plus exponent
    localparam int unsigned PP_W       = 4;
    localparam int unsigned PP_EXP_W   = 6;
    localparam int unsigned PP_EXP_MAX = 37;

    // Width of the static cost figure reported by every cell
    localparam int unsigned COST_W     = 51;

    typedef enum logic [1:0] {
        StAcc  = 2'd0,
        StNorm = 2'd1,
        StOut  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/leading_one_detector.sv
// Combinational leading-one detector.
//   mag    in  W         : unsigned magnitude
//   pos    out clog2(W)  : bit index of the most significant set bit (0 when zero)
//   zero   out 1         : mag is all zeros
//   number out COST_W    : static cost figure, one priority cell per input bit
module leading_one_detector
    import mac_pkg::*;
#(
    parameter int unsigned W = 48
) (
    input  logic [W-1:0]         mag,
    output logic [$clog2(W)-1:0] pos,
    output logic                 zero,
    output logic [COST_W-1:0]    number
);

    localparam int unsigned PW = $clog2(W);

    // Scan upward so the highest set bit is the last assignment to win
    always_comb begin
        pos = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (mag[i]) begin
                pos = PW'(i);
            end
        end
    end

    assign zero   = (mag == '0);
    assign number = COST_W'(W);

endmodule

// File: rtl/pp_accumulator.sv
// Accumulates N_TERMS sign-magnitude partial products into an exact two's
// complement register (LSB = 2^-2), then normalizes the sum into the 8-bit
// image float {S, E[4:0], M[1:0]} with truncation, flush-to-zero and saturation.
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : term handshake on pp / exp
//   pp, exp                : term {sign, lead, mant[1:0]} and exponent 0..37
//   out_valid/out_ready    : result handshake on out_data
//   out_data               : normalized result
//   number                 : static cost figure of instantiated cells
module pp_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned N_TERMS   = 9,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned OUT_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PP_W-1:0]     pp,
    input  logic [PP_EXP_W-1:0] exp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IMG_W-1:0]    out_data,
    output logic [COST_W-1:0]   number
);

    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int unsigned POS_W = $clog2(ACC_W);

    acc_state_e             state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IMG_W-1:0]       out_q, out_d;

    logic [ACC_W-1:0]       mag;
    logic [ACC_W-1:0]       abs_v;
    logic                   sign;
    logic [POS_W-1:0]       lod_pos;
    logic                   lod_zero;
    logic [COST_W-1:0]      lod_number;
    logic                   xfer;
    int                     e_int;
    logic [IMG_MANT_W-1:0]  mant;
    logic [IMG_W-1:0]       result;

    // Term magnitude; pp = 0 yields 0 regardless of exp
    assign mag   = ACC_W'(pp[2:0]) << exp;
    assign sign  = acc_q[ACC_W-1];
    assign abs_v = sign ? (~acc_q + 1'b1) : acc_q;
    assign xfer  = in_valid && in_ready;

    leading_one_detector #(
        .W (ACC_W)
    ) u_lod (
        .mag    (abs_v),
        .pos    (lod_pos),
        .zero   (lod_zero),
        .number (lod_number)
    );

    assign number = lod_number;

    // Normalization: value = 1.M * 2^(p-2) in real units, so E = p - 2 - OUT_SHIFT.
    // Appending two zero LSBs supplies the missing mantissa bits when p < 2.
    always_comb begin
        e_int  = int'(lod_pos) - 2 - int'(OUT_SHIFT);
        mant   = IMG_MANT_W'({abs_v, 2'b00} >> lod_pos);
        result = '0;
        if (lod_zero || (e_int < 0) || ((e_int == 0) && (mant == '0))) begin
            result = '0;
        end else if (e_int > 31) begin
            result = {sign, 5'h1F, 2'b11};
        end else begin
            result = {sign, IMG_EXP_W'(e_int), mant};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAcc: begin
                in_ready = 1'b1;
                if (xfer) begin
                    acc_d = pp[3] ? (acc_q - mag) : (acc_q + mag);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_TERMS - 1)) begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                out_d   = result;
                state_d = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAcc;
                end
            end
            default: begin
                state_d = StAcc;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator with OUT_SHIFT = 0 and hand-computed results.
module tb_pp_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  pp;
    logic [5:0]  exp;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [50:0] number;

    int checks = 0;
    int errors = 0;

    pp_accumulator #(
        .N_TERMS   (9),
        .ACC_W     (48),
        .OUT_SHIFT (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp        (pp),
        .exp       (exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .number    (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_terms(input logic [8:0][3:0] pv, input logic [8:0][5:0] ev,
                              input int count, input bit gapped);
        for (int i = 0; i < count; i++) begin
            if (gapped) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            pp       = pv[i];
            exp      = ev[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        pp       = '0;
        exp      = '0;
    endtask

    // Sends a full window, checks latency, holds the result, then handshakes.
    task automatic run_window(input string tag, input logic [8:0][3:0] pv,
                              input logic [8:0][5:0] ev, input bit gapped,
                              input logic [7:0] expected, input int hold);
        send_terms(pv, ev, 9, gapped);
        check_eq({tag, "_norm_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_norm_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(expected));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_data"}, 32'(out_data), 32'(expected));
            check_eq({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_after_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_after_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [8:0][3:0] pv;
    logic [8:0][5:0] ev;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp        = '0;
        exp       = '0;
        do_reset();

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);

        // 9 x 1.00*2^4 = 144 = 1.001*2^7 -> {0,00111,00}
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0100; ev[i] = 6'd4; end
        run_window("sum144", pv, ev, 1'b0, 8'h1C, 0);

        // +4 and -4 copies of 1.00*2^4 cancel; zero term with large exp
        for (int i = 0; i < 4; i++) begin pv[i] = 4'b0100; ev[i] = 6'd4; end
        for (int i = 4; i < 8; i++) begin pv[i] = 4'b1100; ev[i] = 6'd4; end
        pv[8] = 4'b0000; ev[8] = 6'd9;
        run_window("cancel", pv, ev, 1'b0, 8'h00, 0);

        // -1.10*2^10 -> {1,01010,10}
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0000; ev[i] = 6'd0; end
        pv[0] = 4'b1110; ev[0] = 6'd10;
        run_window("neg", pv, ev, 1'b0, 8'hAA, 0);

        // 9 x 1.11*2^37 -> exponent 40, saturate
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0111; ev[i] = 6'd37; end
        run_window("sat", pv, ev, 1'b0, 8'h7F, 0);

        // 1.00*2^0 -> E=0, M=0 -> flush
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0000; ev[i] = 6'd0; end
        pv[0] = 4'b0100; ev[0] = 6'd0;
        run_window("flush", pv, ev, 1'b0, 8'h00, 0);

        // Backpressure hold, then an independent window: 1.01*2^3 -> {0,00011,01}
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0100; ev[i] = 6'd4; end
        run_window("hold", pv, ev, 1'b0, 8'h1C, 5);
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0000; ev[i] = 6'd0; end
        pv[3] = 4'b0101; ev[3] = 6'd3;
        run_window("indep", pv, ev, 1'b0, 8'h0D, 0);

        // Reset after 4 terms discards the partial sum
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0111; ev[i] = 6'd20; end
        send_terms(pv, ev, 4, 1'b0);
        do_reset();
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0100; ev[i] = 6'd4; end
        run_window("after_rst", pv, ev, 1'b0, 8'h1C, 0);

        // Reset during OUT drops the pending result
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0101; ev[i] = 6'd8; end
        send_terms(pv, ev, 9, 1'b0);
        @(posedge clk);
        #1;
        check_eq("outrst_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        check_eq("outrst_valid", 32'(out_valid), 32'd0);
        check_eq("outrst_data", 32'(out_data), 32'd0);
        check_eq("outrst_ready", 32'(in_ready), 32'd1);

        // Gapped input gives the same result
        for (int i = 0; i < 9; i++) begin pv[i] = 4'b0100; ev[i] = 6'd4; end
        run_window("gapped", pv, ev, 1'b1, 8'h1C, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
